keypad_entry: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces it, and emits one key event per press. Decimal keys are shifted into an 8-digit BCD entry buffer. It sits directly upstream of the seven-segment scan/display stage, which renders `disp_digits` on the DIG/Y outputs. Non-decimal keys are reported as events for the control FSM.

---
 rtl/keypad_pkg.sv | 50 +++++
 rtl/scan_tick.sv | 24 ++
 rtl/keypad_entry.sv | 111 +++++++++++
 tb/tb_keypad_entry.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key codes and the row/column -> key code map for the keypad front end.
// Pure declarations; no timing or flow control of its own.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   localparam logic [3:0] KEY_A   = 4'hA;
   localparam logic [3:0] KEY_B   = 4'hB;
   localparam logic [3:0] KEY_C   = 4'hC;
   localparam logic [3:0] KEY_D   = 4'hD;
   localparam logic [3:0] KEY_E   = 4'hE;
   localparam logic [3:0] KEY_F   = 4'hF;
   localparam logic [3:0] KEY_CLR = 4'hC;

   // Physical layout: * reports as E, # as F.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      code = 4'h0;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = KEY_A;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = KEY_B;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = KEY_C;
         4'hC: code = KEY_E;
         4'hD: code = 4'h0;
         4'hE: code = KEY_F;
         4'hF: code = KEY_D;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   function automatic logic [1:0] low_row(input logic [3:0] r);
      logic [1:0] idx;
      if (!r[0])      idx = 2'd0;
      else if (!r[1]) idx = 2'd1;
      else if (!r[2]) idx = 2'd2;
      else            idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider: one-cycle tick every DIV clocks, on the last count before wrap.
// Latency fixed at DIV cycles per tick; never stalls, no backpressure.
module scan_tick #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + W'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner/debouncer; one event per press, decimal keys shift into an 8-digit BCD buffer.
// Event lands DEB_TICKS ticks after first detection; no backpressure, key_valid is a one-cycle pulse.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int DEB_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_down,
   output logic [31:0] disp_digits
);

   localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS);

   logic [3:0] row_m, row_s;
   logic       tick;
   state_t     state;
   logic [1:0] col_idx;
   logic [1:0] lat_row;
   logic [3:0] deb_cnt;
   logic [3:0] code_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_m <= 4'hF;
         row_s <= 4'hF;
      end else begin
         row_m <= row;
         row_s <= row_m;
      end
   end

   scan_tick #(.DIV(SCAN_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // col stays frozen outside SCAN, so col_idx is also the latched column.
   assign code_now = key_map(lat_row, col_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SCAN;
         col         <= 4'b1110;
         col_idx     <= 2'd0;
         lat_row     <= 2'd0;
         deb_cnt     <= 4'd0;
         key_code    <= 4'd0;
         key_valid   <= 1'b0;
         key_down    <= 1'b0;
         disp_digits <= '0;
      end else begin
         key_valid <= 1'b0;
         if (tick) begin
            case (state)
               SCAN: begin
                  if (row_s != 4'hF) begin
                     lat_row <= low_row(row_s);
                     deb_cnt <= 4'd0;
                     state   <= DEBOUNCE;
                  end else begin
                     col     <= {col[2:0], col[3]};
                     col_idx <= col_idx + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (!row_s[lat_row]) begin
                     if (deb_cnt + 4'd1 == DEB_LAST) begin
                        key_valid <= 1'b1;
                        key_code  <= code_now;
                        key_down  <= 1'b1;
                        deb_cnt   <= 4'd0;
                        state     <= HELD;
                        if (code_now <= 4'd9)
                           disp_digits <= {disp_digits[27:0], code_now};
                        else if (code_now == KEY_CLR)
                           disp_digits <= '0;
                     end else begin
                        deb_cnt <= deb_cnt + 4'd1;
                     end
                  end else begin
                     state <= SCAN;
                  end
               end
               HELD: begin
                  if (row_s[lat_row]) begin
                     if (deb_cnt + 4'd1 == DEB_LAST) begin
                        key_down <= 1'b0;
                        deb_cnt  <= 4'd0;
                        state    <= SCAN;
                     end else begin
                        deb_cnt <= deb_cnt + 4'd1;
                     end
                  end else begin
                     deb_cnt <= 4'd0;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Keypad entry bench: physical keypad model drives rows, a tick-level behavioural model predicts every output.
// Directed scenarios first, then randomized presses with bounce, overlapping keys and stray resets.
module tb_keypad_entry;

   localparam int SCAN_DIV  = 4;
   localparam int DEB_TICKS = 3;
   localparam int P_IDLE = 0, P_ARMED = 1, P_DOWN = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  row = 4'hF;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [31:0] disp_digits;

   keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
      .clk         (clk),
      .rst         (rst),
      .row         (row),
      .col         (col),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_down    (key_down),
      .disp_digits (disp_digits)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int n_ev  = 0;
   logic [15:0] pressed = '0;

   // Key at index r*4+c, straight from the keypad legend.
   int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   // Reference model state, advanced once per clock.
   int          m_div, m_col, m_phase, m_wr, m_wc, m_run;
   logic [3:0]  m_sync0, m_sync1, rs;
   logic [3:0]  e_code;
   logic        e_valid, e_down;
   logic [31:0] e_disp;
   int          digits [$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_div = 0; m_col = 0; m_phase = P_IDLE; m_wr = 0; m_wc = 0; m_run = 0;
         m_sync0 = 4'hF; m_sync1 = 4'hF;
         e_code = 4'h0; e_valid = 1'b0; e_down = 1'b0; e_disp = '0;
         digits.delete();
      end else begin
         rs = m_sync1;
         e_valid = 1'b0;
         if (m_div == SCAN_DIV - 1) begin
            if (m_phase == P_IDLE) begin
               if (rs != 4'hF) begin
                  for (int r = 3; r >= 0; r--) if (!rs[r]) m_wr = r;
                  m_wc = m_col;
                  m_run = 1;
                  m_phase = P_ARMED;
               end else begin
                  m_col = (m_col + 1) % 4;
               end
            end else if (m_phase == P_ARMED) begin
               if (!rs[m_wr]) begin
                  m_run++;
                  if (m_run == DEB_TICKS + 1) begin
                     e_code  = 4'(keymap[m_wr * 4 + m_wc]);
                     e_valid = 1'b1;
                     e_down  = 1'b1;
                     m_phase = P_DOWN;
                     m_run   = 0;
                     if (keymap[m_wr * 4 + m_wc] <= 9) begin
                        digits.push_back(keymap[m_wr * 4 + m_wc]);
                        if (digits.size() > 8) void'(digits.pop_front());
                     end else if (keymap[m_wr * 4 + m_wc] == 12) begin
                        digits.delete();
                     end
                     e_disp = '0;
                     foreach (digits[i]) e_disp = (e_disp << 4) | 32'(digits[i]);
                  end
               end else begin
                  m_phase = P_IDLE;
               end
            end else begin
               m_run = rs[m_wr] ? m_run + 1 : 0;
               if (m_run == DEB_TICKS) begin
                  e_down  = 1'b0;
                  m_phase = P_IDLE;
               end
            end
         end
         m_div   = (m_div + 1) % SCAN_DIV;
         m_sync1 = m_sync0;
         m_sync0 = row;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Check all outputs mid-cycle, then present the keypad rows for the driven column.
   task automatic step(input int n);
      logic [3:0] ecol;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ecol = 4'hF;
         ecol[m_col] = 1'b0;
         chk("col", 32'(col), 32'(ecol));
         chk("key_valid", 32'(key_valid), 32'(e_valid));
         chk("key_code", 32'(key_code), 32'(e_code));
         chk("key_down", 32'(key_down), 32'(e_down));
         chk("disp_digits", disp_digits, e_disp);
         if (key_valid) n_ev++;
         for (int r = 0; r < 4; r++) row[r] = ~pressed[r * 4 + m_col];
      end
   endtask

   task automatic press(input int k, input int hold, input int gap);
      pressed[k] = 1'b1;
      step(hold);
      pressed[k] = 1'b0;
      step(gap);
   endtask

   int digit_key [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   int k, k2;

   initial begin
      #2 rst = 1'b1;
      step(3);
      chk("rst_col", 32'(col), 32'h0000_000E);
      chk("rst_disp", disp_digits, 32'h0);
      rst = 1'b0;
      step(20);

      // single press of "5"
      n_ev = 0;
      press(5, 60, 40);
      chk("k5_events", n_ev, 1);
      chk("k5_code", 32'(key_code), 32'h5);
      chk("k5_disp", disp_digits, 32'h0000_0005);

      // bouncing "5": alternate every tick, then stable
      n_ev = 0;
      for (int i = 0; i < 5; i++) begin
         pressed[5] = 1'b1; step(SCAN_DIV);
         pressed[5] = 1'b0; step(SCAN_DIV);
      end
      chk("bounce_quiet", n_ev, 0);
      press(5, 60, 40);
      chk("bounce_events", n_ev, 1);
      chk("bounce_disp", disp_digits, 32'h0000_0055);

      // nine digits overflow the buffer, then clear
      for (int i = 0; i < 9; i++) press(digit_key[i], 60, 40);
      chk("digits_disp", disp_digits, 32'h2345_6789);
      n_ev = 0;
      press(11, 60, 40);
      chk("clr_events", n_ev, 1);
      chk("clr_code", 32'(key_code), 32'hC);
      chk("clr_disp", disp_digits, 32'h0);

      // "1" held, "9" added: only "1" reported
      n_ev = 0;
      pressed[0] = 1'b1; step(60);
      pressed[10] = 1'b1; step(60);
      chk("two_events", n_ev, 1);
      chk("two_code", 32'(key_code), 32'h1);
      pressed = '0; step(40);
      n_ev = 0;
      press(10, 60, 40);
      chk("nine_events", n_ev, 1);
      chk("nine_code", 32'(key_code), 32'h9);

      // reset while "0" is being debounced
      pressed[13] = 1'b1;
      for (int i = 0; i < 200 && m_phase != P_ARMED; i++) step(1);
      chk("armed_bound", (m_phase == P_ARMED) ? 32'h1 : 32'h0, 32'h1);
      step(1);
      n_ev = 0;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      chk("rst_no_event", n_ev, 0);
      step(80);
      chk("refire_events", n_ev, 1);
      chk("refire_code", 32'(key_code), 32'h0);
      chk("refire_disp", disp_digits, 32'h0);
      pressed = '0; step(40);

      // randomized presses
      for (int it = 0; it < 40; it++) begin
         k = $urandom_range(0, 15);
         repeat ($urandom_range(0, 3)) begin
            pressed[k] = 1'b1; step($urandom_range(1, 6));
            pressed[k] = 1'b0; step($urandom_range(1, 6));
         end
         pressed[k] = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            k2 = $urandom_range(0, 15);
            step($urandom_range(5, 30));
            pressed[k2] = 1'b1;
         end
         step($urandom_range(10, 60));
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1; step(2); rst = 1'b0;
         end
         step($urandom_range(0, 20));
         pressed = '0;
         step($urandom_range(5, 60));
      end

      step(10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
